uart_rx_checked: RTL and testbench

- Serial receive end for the line our transmitter drives.
- Deframes 1 start + DBIT data (LSB first) + optional parity + stop.
- Samples on the shared 16x baud tick from the baud-rate timer and majority-votes each bit.
- Reports parity, framing and break conditions alongside each byte, for feeding the RX FIFO with error flags; drop-in alternative to the plain receiver.

---
 rtl/uart_rx_checked.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx_checked.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_checked.sv
// UART receiver with majority-voted sampling and per-frame error flags.
// The frame is 1 start bit, DBIT data bits sent LSB first, an optional
// parity bit and a stop bit lasting SB_TICK ticks. All timing comes from a
// 16x-baud s_tick pulse. Each completed frame delivers the data word and its
// parity, framing and break flags together, so the RX FIFO can store them
// side by side.
module uart_rx_checked #(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned SB_TICK    = 16,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick,
    output logic            parity_err,
    output logic            frame_err,
    output logic            break_det,
    output logic            busy
);

    // The tick counter must reach SB_TICK-1 in STOP and 15 in every other bit.
    localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [SW-1:0] S_SMP0     = SW'(6);
    localparam logic [SW-1:0] S_SMP1     = SW'(7);
    localparam logic [SW-1:0] S_VOTE     = SW'(8);
    localparam logic [SW-1:0] S_BIT_LAST = SW'(15);
    localparam logic [SW-1:0] S_STP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

    localparam logic PAR_ON  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [1:0]      sync_q;
    logic            rs;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [1:0]      smp_q, smp_d;
    logic            vote_q, vote_d;
    logic            par_q, par_d;
    logic            vote_c;

    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            perr_q, perr_d;
    logic            ferr_q, ferr_d;
    logic            brk_q, brk_d;
    logic            busy_q, busy_d;

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rs = sync_q[1];

    // Majority of the samples taken at s=6, s=7 and the live value at s=8.
    assign vote_c = (smp_q[0] & smp_q[1]) | (smp_q[0] & rs) | (smp_q[1] & rs);

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            smp_q   <= '0;
            vote_q  <= 1'b0;
            par_q   <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            smp_q   <= smp_d;
            vote_q  <= vote_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: deframing, sampling and end-of-frame flag capture.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        smp_d   = smp_q;
        vote_d  = vote_q;
        par_d   = par_q;
        dout_d  = dout_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        brk_d   = 1'b0;

        // Mid-bit sampling is common to every state that times a bit.
        if (state_q != IDLE && s_tick) begin
            if (s_q == S_SMP0) smp_d[0] = rs;
            if (s_q == S_SMP1) smp_d[1] = rs;
            if (s_q == S_VOTE) vote_d   = vote_c;
        end

        case (state_q)
            IDLE: begin
                // Start detection is not gated by s_tick.
                if (!rs) begin
                    state_d = START;
                    s_d     = '0;
                end
            end

            START: begin
                if (s_tick) begin
                    if (s_q == S_VOTE && vote_c) begin
                        // Start bit did not survive the vote: false start.
                        state_d = IDLE;
                        s_d     = '0;
                    end else if (s_q == S_BIT_LAST) begin
                        state_d = DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            DATA: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        s_d = '0;
                        b_d = {vote_q, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = PAR_ON ? PARITY : STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            PARITY: begin
                if (s_tick) begin
                    if (s_q == S_BIT_LAST) begin
                        par_d   = vote_q;
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STP_LAST) begin
                        // Deliver data and flags even for bad frames.
                        state_d = IDLE;
                        s_d     = '0;
                        dout_d  = b_q;
                        perr_d  = PAR_ON && ((^b_q ^ par_q) != PAR_ODD);
                        ferr_d  = ~vote_q;
                        done_d  = 1'b1;
                        brk_d   = (b_q == '0) && (!PAR_ON || !par_q) && !vote_q;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                s_d     = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign rx_dout      = dout_q;
    assign rx_done_tick = done_q;
    assign parity_err   = perr_q;
    assign frame_err    = ferr_q;
    assign break_det    = brk_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_checked.sv
// Bench for uart_rx_checked: builds a tick-level line waveform, plays it
// into the receiver and compares delivered frames with a line decoder.
module tb_uart_rx_checked;

    localparam int DBIT  = 8;
    localparam int SB    = 16;
    localparam int PEN   = 1;
    localparam int PODD  = 0;
    localparam int NBITS = 1 + DBIT + PEN;   // bits before the stop bit

    logic            clk;
    logic            reset_n;
    logic            s_tick;
    logic            rx;
    logic [DBIT-1:0] rx_dout;
    logic            rx_done_tick;
    logic            parity_err;
    logic            frame_err;
    logic            break_det;
    logic            busy;

    uart_rx_checked #(
        .DBIT       (DBIT),
        .SB_TICK    (SB),
        .PARITY_EN  (PEN),
        .PARITY_ODD (PODD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_tick       (s_tick),
        .rx           (rx),
        .rx_dout      (rx_dout),
        .rx_done_tick (rx_done_tick),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .break_det    (break_det),
        .busy         (busy)
    );

    typedef struct {
        logic [DBIT-1:0] d;
        logic            pe;
        logic            fe;
        logic            bk;
    } rec_t;

    int   n_vec = 0;
    int   n_err = 0;
    bit   line_q[$];      // one line level per s_tick period
    rec_t obs_q[$];
    rec_t exp_q[$];
    bit   prev_done     = 1'b0;
    bit   busy_seen     = 1'b0;
    bit   busy_chk_en   = 1'b0;
    bit   busy_chk_next = 1'b0;
    int   tcnt          = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // s_tick: one clock in four.
    initial begin
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tcnt   = (tcnt + 1) % 4;
            s_tick = (tcnt == 0);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: collects done events and checks pulse shape.
    always @(negedge clk) begin
        if (busy) busy_seen = 1'b1;
        if (busy_chk_next) begin
            busy_chk_next = 1'b0;
            check_eq("busy_after_done", 32'(busy), 32'd0);
        end
        if (break_det && !rx_done_tick) check_eq("break_without_done", 32'(rx_done_tick), 32'd1);
        if (rx_done_tick) begin
            rec_t r;
            check_eq("done_width", 32'(prev_done), 32'd0);
            r.d  = rx_dout;
            r.pe = parity_err;
            r.fe = frame_err;
            r.bk = break_det;
            obs_q.push_back(r);
            if (busy_chk_en) busy_chk_next = 1'b1;
        end
        prev_done = rx_done_tick;
    end

    task automatic wait_tick();
        do @(posedge clk); while (s_tick !== 1'b1);
    endtask

    task automatic add_level(input bit v, input int n);
        for (int i = 0; i < n; i++) line_q.push_back(v);
    endtask

    function automatic bit good_par(input logic [DBIT-1:0] d);
        return (^d) ^ bit'(PODD);
    endfunction

    task automatic add_frame(input logic [DBIT-1:0] d, input bit p, input bit stp);
        add_level(1'b0, 16);
        for (int i = 0; i < DBIT; i++) add_level(d[i], 16);
        if (PEN != 0) add_level(p, 16);
        add_level(stp, SB);
    endtask

    function automatic bit maj3(input bit a, input bit b, input bit c);
        return (int'(a) + int'(b) + int'(c)) >= 2;
    endfunction

    function automatic bit bit_at(input int st, input int j);
        int base;
        base = st + 16 * j;
        return maj3(line_q[base + 6], line_q[base + 7], line_q[base + 8]);
    endfunction

    // Reference decoder over the tick waveform. A low level in period k
    // starts a frame whose tick 0 is k; bit j is voted from ticks
    // 16j+6..8. After returning to idle at tick t, a low line at t or t+1
    // starts the next frame at t+1.
    task automatic model_decode();
        int  len;
        int  k;
        int  st;
        int  fend;
        bit  forced;
        len    = line_q.size();
        k      = 0;
        forced = 1'b0;
        while (k < len) begin
            if (!forced && line_q[k] != 1'b0) begin
                k++;
                continue;
            end
            forced = 1'b0;
            st = k;
            if (st + 8 >= len) break;
            if (bit_at(st, 0)) begin
                forced = (line_q[st + 8] == 1'b0);
                k      = st + 9;
                continue;
            end
            fend = st + 16 * NBITS + SB - 1;
            if (fend >= len) break;
            begin
                rec_t r;
                bit   par;
                bit   stp;
                for (int i = 0; i < DBIT; i++) r.d[i] = bit_at(st, 1 + i);
                par  = (PEN != 0) ? bit_at(st, 1 + DBIT) : 1'b0;
                stp  = bit_at(st, NBITS);
                r.pe = (PEN != 0) && (((^r.d) ^ par) != bit'(PODD));
                r.fe = !stp;
                r.bk = (r.d == '0) && !par && !stp;
                exp_q.push_back(r);
            end
            forced = (line_q[fend] == 1'b0);
            k      = fend + 1;
        end
    endtask

    task automatic drive_line(input int lim);
        for (int k = 0; k < lim; k++) begin
            wait_tick();
            #1;
            rx = line_q[k];
        end
        wait_tick();
        #1;
        rx = 1'b1;
    endtask

    task automatic run_scenario(input string name, input bit chk_busy);
        int nmin;
        add_level(1'b1, 200);
        obs_q.delete();
        exp_q.delete();
        model_decode();
        busy_chk_en = chk_busy;
        drive_line(line_q.size());
        repeat (4) @(posedge clk);
        busy_chk_en = 1'b0;
        check_eq($sformatf("%s.frames", name), 32'(obs_q.size()), 32'(exp_q.size()));
        nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) begin
            check_eq($sformatf("%s.f%0d.data", name, i), 32'(obs_q[i].d), 32'(exp_q[i].d));
            check_eq($sformatf("%s.f%0d.perr", name, i), 32'(obs_q[i].pe), 32'(exp_q[i].pe));
            check_eq($sformatf("%s.f%0d.ferr", name, i), 32'(obs_q[i].fe), 32'(exp_q[i].fe));
            check_eq($sformatf("%s.f%0d.brk", name, i), 32'(obs_q[i].bk), 32'(exp_q[i].bk));
        end
        if (exp_q.size() > 0)
            check_eq($sformatf("%s.dout_hold", name), 32'(rx_dout), 32'(exp_q[exp_q.size()-1].d));
        check_eq($sformatf("%s.busy_idle", name), 32'(busy), 32'd0);
        line_q.delete();
    endtask

    initial begin
        int idx;
        reset_n = 1'b0;
        rx      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.dout", 32'(rx_dout), 32'd0);
        check_eq("rst.done", 32'(rx_done_tick), 32'd0);
        check_eq("rst.perr", 32'(parity_err), 32'd0);
        check_eq("rst.ferr", 32'(frame_err), 32'd0);
        check_eq("rst.brk", 32'(break_det), 32'd0);
        check_eq("rst.busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);

        // Clean frame.
        add_level(1'b1, 4);
        add_frame(8'hA5, 1'b0, 1'b1);
        run_scenario("a5", 1'b1);
        check_eq("a5.dout_const", 32'(rx_dout), 32'h0A5);

        // Parity error, then a good frame clears it.
        add_level(1'b1, 4);
        add_frame(8'h3C, 1'b1, 1'b1);
        add_level(1'b1, 3);
        add_frame(8'h01, 1'b1, 1'b1);
        run_scenario("par", 1'b1);
        check_eq("par.perr_const", 32'(parity_err), 32'd0);

        // Stop bit low: framing error, not a break.
        add_level(1'b1, 4);
        add_frame(8'h55, 1'b0, 1'b0);
        run_scenario("stop0", 1'b0);
        check_eq("stop0.ferr_const", 32'(frame_err), 32'd1);

        // False start: low for 5 ticks only.
        busy_seen = 1'b0;
        add_level(1'b1, 4);
        add_level(1'b0, 5);
        run_scenario("false_start", 1'b0);
        check_eq("false_start.busy_seen", 32'(busy_seen), 32'd1);
        add_level(1'b1, 4);
        add_frame(8'h81, 1'b0, 1'b1);
        run_scenario("after_false", 1'b1);

        // Line held low for 12 bit times.
        add_level(1'b1, 4);
        add_level(1'b0, 12 * 16);
        run_scenario("break", 1'b0);

        // Single low tick at s=7 of data bit 3.
        add_level(1'b1, 4);
        idx = line_q.size() + 16 * 4 + 7;
        add_frame(8'hFF, 1'b0, 1'b1);
        line_q[idx] = 1'b0;
        run_scenario("glitch", 1'b1);
        check_eq("glitch.dout_const", 32'(rx_dout), 32'h0FF);

        // Back-to-back frames with no idle gap.
        add_level(1'b1, 4);
        add_frame(8'h12, good_par(8'h12), 1'b1);
        add_frame(8'h34, good_par(8'h34), 1'b1);
        run_scenario("b2b", 1'b1);

        // Reset in the middle of DATA aborts the frame.
        obs_q.delete();
        add_level(1'b1, 4);
        add_frame(8'h5A, good_par(8'h5A), 1'b1);
        drive_line(4 + 16 * 5 + 5);
        check_eq("midrst.busy_before", 32'(busy), 32'd1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("midrst.dout", 32'(rx_dout), 32'd0);
        check_eq("midrst.busy", 32'(busy), 32'd0);
        check_eq("midrst.done", 32'(rx_done_tick), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_eq("midrst.no_frame", 32'(obs_q.size()), 32'd0);
        line_q.delete();
        repeat (3) @(posedge clk);
        add_level(1'b1, 4);
        add_frame(8'hC3, good_par(8'hC3), 1'b1);
        run_scenario("after_rst", 1'b1);

        // Randomized frames: bad parity/stop, gaps, glitches, low runs.
        add_level(1'b1, 4);
        for (int f = 0; f < 16; f++) begin
            logic [DBIT-1:0] d;
            bit              p;
            bit              stp;
            int              base;
            d    = DBIT'($urandom);
            p    = good_par(d) ^ ($urandom_range(0, 3) == 0);
            stp  = ($urandom_range(0, 4) != 0);
            base = line_q.size();
            add_frame(d, p, stp);
            if ($urandom_range(0, 2) == 0) begin
                idx = base + $urandom_range(0, 16 * NBITS + SB - 1);
                line_q[idx] = !line_q[idx];
            end
            if ($urandom_range(0, 7) == 0) add_level(1'b0, $urandom_range(1, 40));
            add_level(1'b1, $urandom_range(0, 20));
        end
        run_scenario("rand", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
